// File: rtl/adpll_loop_sequencer.sv
// rtl/adpll_loop_sequencer.sv - ADPLL window sequencer driving the UpDownCounter
//
// Turns phase-detector early/late flags into up/down/hold instructions for the
// UpDownCounter over fixed measurement windows. At each window end it waits one
// cycle for the last instruction to land, samples the counter value, clears the
// counter, publishes the signed sum and updates the lock tracker.
//
// Ports:
//   fpga_clk_i      in   1      clock, all logic on rising edge
//   reset_n_i       in   1      synchronous active-low reset
//   enable_i        in   1      1 = run windows, 0 = abort to idle
//   early_i         in   1      reference leads DCO
//   late_i          in   1      reference lags DCO
//   counter_val_i   in   WIDTH  UpDownCounter value (two's complement)
//   count_instr_o   out  2      00 hold, 01 up, 10 down
//   clear_o         out  1      UpDownCounter clear
//   sample_o        out  WIDTH  last captured window sum (signed)
//   sample_valid_o  out  1      one-cycle strobe when sample_o updates
//   locked_o        out  1      lock indicator

module adpll_loop_sequencer #(
  parameter int WIDTH      = 20,
  parameter int WINDOW_LEN = 64,
  parameter int LOCK_TOL   = 4,
  parameter int LOCK_COUNT = 8
) (
  input  logic             fpga_clk_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic             early_i,
  input  logic             late_i,
  input  logic [WIDTH-1:0] counter_val_i,
  output logic [1:0]       count_instr_o,
  output logic             clear_o,
  output logic [WIDTH-1:0] sample_o,
  output logic             sample_valid_o,
  output logic             locked_o
);

  localparam int WIN_W  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);

  // Guard limits sit one step inside the representable range: the counter
  // applies an instruction one cycle after we issue it, so one more step may
  // still be in flight when the guard trips.
  localparam logic signed [WIDTH-1:0] UP_LIMIT = {1'b0, {(WIDTH-2){1'b1}}, 1'b0};
  localparam logic signed [WIDTH-1:0] DN_LIMIT = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [WIDTH-1:0] TOL_POS  = WIDTH'(LOCK_TOL);
  localparam logic signed [WIDTH-1:0] TOL_NEG  = -TOL_POS;

  localparam logic [1:0] INSTR_HOLD = 2'b00;
  localparam logic [1:0] INSTR_UP   = 2'b01;
  localparam logic [1:0] INSTR_DOWN = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    SETTLE,
    SAMPLE,
    CLEAR
  } state_t;

  state_t             state, state_nxt;
  logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
  logic [LOCK_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic [1:0]         instr_nxt;
  logic               clear_nxt;
  logic [WIDTH-1:0]   sample_nxt;
  logic               valid_nxt;
  logic               locked_nxt;

  logic signed [WIDTH-1:0] cval;
  logic                    up_req;
  logic                    dn_req;
  logic                    in_tol;

  assign cval   = $signed(counter_val_i);
  assign up_req = early_i & ~late_i;
  assign dn_req = late_i & ~early_i;
  // The symmetric band test rejects the most-negative value on its own.
  assign in_tol = (cval >= TOL_NEG) && (cval <= TOL_POS);

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      win_cnt        <= '0;
      lock_cnt       <= '0;
      count_instr_o  <= INSTR_HOLD;
      clear_o        <= 1'b1;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      locked_o       <= 1'b0;
    end else begin
      state          <= state_nxt;
      win_cnt        <= win_cnt_nxt;
      lock_cnt       <= lock_cnt_nxt;
      count_instr_o  <= instr_nxt;
      clear_o        <= clear_nxt;
      sample_o       <= sample_nxt;
      sample_valid_o <= valid_nxt;
      locked_o       <= locked_nxt;
    end
  end

  // Outputs are computed for the next cycle, so each state's values here
  // become visible while the FSM sits in the following state.
  always_comb begin
    state_nxt    = state;
    win_cnt_nxt  = win_cnt;
    lock_cnt_nxt = lock_cnt;
    instr_nxt    = INSTR_HOLD;
    clear_nxt    = 1'b0;
    sample_nxt   = sample_o;
    valid_nxt    = 1'b0;
    locked_nxt   = locked_o;

    if (!enable_i) begin
      state_nxt    = IDLE;
      win_cnt_nxt  = '0;
      clear_nxt    = 1'b1;
      lock_cnt_nxt = '0;
      locked_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = COUNT;
          win_cnt_nxt = '0;
        end
        COUNT: begin
          if (up_req && (cval < UP_LIMIT)) begin
            instr_nxt = INSTR_UP;
          end else if (dn_req && (cval > DN_LIMIT)) begin
            instr_nxt = INSTR_DOWN;
          end
          if (win_cnt == WIN_W'(WINDOW_LEN - 1)) begin
            state_nxt = SETTLE;
          end else begin
            win_cnt_nxt = win_cnt + WIN_W'(1);
          end
        end
        SETTLE: begin
          state_nxt = SAMPLE;
        end
        SAMPLE: begin
          state_nxt  = CLEAR;
          sample_nxt = counter_val_i;
          valid_nxt  = 1'b1;
          clear_nxt  = 1'b1;
          if (in_tol) begin
            if (lock_cnt < LOCK_W'(LOCK_COUNT)) begin
              lock_cnt_nxt = lock_cnt + LOCK_W'(1);
            end
            locked_nxt = (lock_cnt_nxt == LOCK_W'(LOCK_COUNT));
          end else begin
            lock_cnt_nxt = '0;
            locked_nxt   = 1'b0;
          end
        end
        CLEAR: begin
          state_nxt   = COUNT;
          win_cnt_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
          clear_nxt = 1'b1;
        end
      endcase
    end
  end

endmodule
